// File: rtl/uart_param.sv
// Parametrised full-duplex UART: independent TX and RX state machines on one clock,
// RX words land in a small FIFO carrying per-word parity/frame error flags.
module uart_param #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_l,
  input  logic                 xmitH,
  input  logic [DATA_BITS-1:0] xmit_dataH,
  output logic                 xmit_readyH,
  output logic                 xmit_doneH,
  output logic                 uart_XMIT_dataH,
  input  logic                 uart_REC_dataH,
  output logic [DATA_BITS-1:0] rec_dataH,
  output logic                 rec_readyH,
  input  logic                 rec_popH,
  output logic                 rec_parity_errH,
  output logic                 rec_frame_errH,
  output logic                 rec_overrunH,
  input  logic                 rec_clr_errH
);

  localparam int TW = $clog2(CLK_DIV);
  localparam int DW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 2;

  localparam logic [TW-1:0] BIT_LAST  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TX_END    = TW'(CLK_DIV - 2);
  localparam logic [TW-1:0] RX_MID    = TW'(CLK_DIV / 2);
  localparam logic [DW-1:0] DATA_LAST = DW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- transmitter ----------------
  state_t                 tx_state_q;
  logic [TW-1:0]          tx_timer_q;
  logic [DW-1:0]          tx_bit_q;
  logic                   tx_stop_q;
  logic [DATA_BITS-1:0]   tx_shift_q;
  logic                   tx_par_q;
  logic                   tx_line_q;
  logic                   tx_ready_q;
  logic                   tx_done_q;

  // The last stop bit ends one cycle early in STOP; its final cycle is spent in IDLE
  // so ready/done line up with the frame end and back-to-back frames have no gap.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      tx_state_q <= S_IDLE;
      tx_timer_q <= '0;
      tx_bit_q   <= '0;
      tx_stop_q  <= 1'b0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_line_q  <= 1'b1;
      tx_ready_q <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (tx_state_q)
        S_IDLE: begin
          if (xmitH && tx_ready_q) begin
            tx_shift_q <= xmit_dataH;
            tx_par_q   <= (PARITY == 1) ? ~^xmit_dataH : ^xmit_dataH;
            tx_line_q  <= 1'b0;
            tx_ready_q <= 1'b0;
            tx_timer_q <= '0;
            tx_state_q <= S_START;
          end
        end
        S_START: begin
          if (tx_timer_q == BIT_LAST) begin
            tx_timer_q <= '0;
            tx_line_q  <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
            tx_bit_q   <= '0;
            tx_state_q <= S_DATA;
          end else begin
            tx_timer_q <= tx_timer_q + TW'(1);
          end
        end
        S_DATA: begin
          if (tx_timer_q == BIT_LAST) begin
            tx_timer_q <= '0;
            if (tx_bit_q == DATA_LAST) begin
              tx_stop_q <= 1'b0;
              if (PARITY != 0) begin
                tx_line_q  <= tx_par_q;
                tx_state_q <= S_PARITY;
              end else begin
                tx_line_q  <= 1'b1;
                tx_state_q <= S_STOP;
              end
            end else begin
              tx_line_q  <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
              tx_bit_q   <= tx_bit_q + DW'(1);
            end
          end else begin
            tx_timer_q <= tx_timer_q + TW'(1);
          end
        end
        S_PARITY: begin
          if (tx_timer_q == BIT_LAST) begin
            tx_timer_q <= '0;
            tx_line_q  <= 1'b1;
            tx_stop_q  <= 1'b0;
            tx_state_q <= S_STOP;
          end else begin
            tx_timer_q <= tx_timer_q + TW'(1);
          end
        end
        S_STOP: begin
          if (tx_stop_q == STOP_LAST && tx_timer_q == TX_END) begin
            tx_timer_q <= '0;
            tx_ready_q <= 1'b1;
            tx_done_q  <= 1'b1;
            tx_state_q <= S_IDLE;
          end else if (tx_timer_q == BIT_LAST) begin
            tx_timer_q <= '0;
            tx_stop_q  <= 1'b1;
          end else begin
            tx_timer_q <= tx_timer_q + TW'(1);
          end
        end
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end

  assign uart_XMIT_dataH = tx_line_q;
  assign xmit_readyH     = tx_ready_q;
  assign xmit_doneH      = tx_done_q;

  // ---------------- receiver ----------------
  state_t                 rx_state_q;
  logic                   rx_sync1_q;
  logic                   rx_sync2_q;
  logic                   rx_prev_q;
  logic [TW-1:0]          rx_timer_q;
  logic [DW-1:0]          rx_bit_q;
  logic                   rx_stop_q;
  logic [DATA_BITS-1:0]   rx_shift_q;
  logic                   rx_perr_q;
  logic                   rx_ferr_q;

  // Timer is loaded with 1 on the detected edge so that it reads k exactly k cycles later.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      rx_state_q <= S_IDLE;
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_timer_q <= '0;
      rx_bit_q   <= '0;
      rx_stop_q  <= 1'b0;
      rx_shift_q <= '0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_sync1_q <= uart_REC_dataH;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
      case (rx_state_q)
        S_IDLE: begin
          if (rx_prev_q && !rx_sync2_q) begin
            rx_timer_q <= TW'(1);
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_state_q <= S_START;
          end
        end
        S_START: begin
          if (rx_timer_q == RX_MID) begin
            rx_timer_q <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_sync2_q ? S_IDLE : S_DATA;
          end else begin
            rx_timer_q <= rx_timer_q + TW'(1);
          end
        end
        S_DATA: begin
          if (rx_timer_q == BIT_LAST) begin
            rx_timer_q <= '0;
            rx_shift_q <= {rx_sync2_q, rx_shift_q[DATA_BITS-1:1]};
            if (rx_bit_q == DATA_LAST) begin
              rx_stop_q  <= 1'b0;
              rx_state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + DW'(1);
            end
          end else begin
            rx_timer_q <= rx_timer_q + TW'(1);
          end
        end
        S_PARITY: begin
          if (rx_timer_q == BIT_LAST) begin
            rx_timer_q <= '0;
            rx_perr_q  <= (^{rx_shift_q, rx_sync2_q}) != (PARITY == 1);
            rx_stop_q  <= 1'b0;
            rx_state_q <= S_STOP;
          end else begin
            rx_timer_q <= rx_timer_q + TW'(1);
          end
        end
        S_STOP: begin
          if (rx_timer_q == BIT_LAST) begin
            rx_timer_q <= '0;
            rx_ferr_q  <= rx_ferr_q | ~rx_sync2_q;
            if (rx_stop_q == STOP_LAST) rx_state_q <= S_IDLE;
            else                        rx_stop_q  <= 1'b1;
          end else begin
            rx_timer_q <= rx_timer_q + TW'(1);
          end
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  logic          rx_push;
  logic [EW-1:0] rx_word;
  assign rx_push = (rx_state_q == S_STOP) && (rx_timer_q == BIT_LAST) && (rx_stop_q == STOP_LAST);
  assign rx_word = {rx_ferr_q | ~rx_sync2_q, rx_perr_q, rx_shift_q};

  // ---------------- RX FIFO ----------------
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic          fifo_empty, fifo_full, do_pop, do_push, ovr_set;
  logic          rec_ready_q, rec_ovr_q;
  logic [EW-1:0] head;

  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop     = rec_popH && !fifo_empty;
    do_push    = rx_push && (!fifo_full || do_pop);
    ovr_set    = rx_push && fifo_full && !do_pop;
    wr_ptr_d   = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d   = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
  end

  always_ff @(posedge sys_clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= rx_word;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rec_ready_q <= 1'b0;
      rec_ovr_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rec_ready_q <= (wr_ptr_d != rd_ptr_d);
      rec_ovr_q   <= ovr_set | (rec_ovr_q & ~rec_clr_errH);
    end
  end

  assign head            = mem_q[rd_ptr_q[AW-1:0]];
  assign rec_dataH       = fifo_empty ? '0 : head[DATA_BITS-1:0];
  assign rec_parity_errH = !fifo_empty && head[DATA_BITS];
  assign rec_frame_errH  = !fifo_empty && head[DATA_BITS+1];
  assign rec_readyH      = rec_ready_q;
  assign rec_overrunH    = rec_ovr_q;

endmodule

// File: tb/tb_uart_param.sv
// Bench for uart_param: three configurations (8N1/16, 8E2/16, 5O1/4) against a
// frame-level model of the line format and a queue model of the RX FIFO.
module tb_uart_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       xmit[3];
  logic [8:0] xdata[3];
  logic       xready[3], xdone[3], txl[3];
  logic       loopb[3], drv[3], rxin[3];
  logic [8:0] rdata[3];
  logic       rready[3], rperr[3], rferr[3], rovr[3], pop[3], clr[3];

  int total = 0;
  int bad   = 0;
  logic [10:0] mq[$];
  bit movr = 1'b0;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int DB  = (gi == 2) ? 5 : 8;
    localparam int PAR = (gi == 0) ? 0 : ((gi == 1) ? 2 : 1);
    localparam int SB  = (gi == 1) ? 2 : 1;
    localparam int CD  = (gi == 2) ? 4 : 16;
    logic [DB-1:0] xd, rd;
    assign xd        = xdata[gi][DB-1:0];
    assign rdata[gi] = 9'(rd);
    assign rxin[gi]  = loopb[gi] ? txl[gi] : drv[gi];
    uart_param #(.DATA_BITS(DB), .PARITY(PAR), .STOP_BITS(SB), .CLK_DIV(CD), .FIFO_DEPTH(4)) u_dut (
      .sys_clk(clk), .sys_rst_l(rst_n),
      .xmitH(xmit[gi]), .xmit_dataH(xd), .xmit_readyH(xready[gi]), .xmit_doneH(xdone[gi]),
      .uart_XMIT_dataH(txl[gi]), .uart_REC_dataH(rxin[gi]),
      .rec_dataH(rd), .rec_readyH(rready[gi]), .rec_popH(pop[gi]),
      .rec_parity_errH(rperr[gi]), .rec_frame_errH(rferr[gi]), .rec_overrunH(rovr[gi]),
      .rec_clr_errH(clr[gi]));
  end

  function automatic int c_db(int i);  return (i == 2) ? 5 : 8; endfunction
  function automatic int c_par(int i); return (i == 0) ? 0 : ((i == 1) ? 2 : 1); endfunction
  function automatic int c_sb(int i);  return (i == 1) ? 2 : 1; endfunction
  function automatic int c_cd(int i);  return (i == 2) ? 4 : 16; endfunction
  function automatic int c_nb(int i);  return 1 + c_db(i) + ((c_par(i) != 0) ? 1 : 0) + c_sb(i); endfunction

  // Line bits in transmission order, index 0 = start bit.
  function automatic logic [15:0] mk_frame(int i, logic [8:0] d, bit flip_par, bit zero_stop);
    logic [15:0] f;
    int k, ones;
    logic p;
    f = '0; k = 1; ones = 0;
    for (int b = 0; b < c_db(i); b++) begin
      f[k] = d[b]; ones += int'(d[b]); k++;
    end
    if (c_par(i) != 0) begin
      p = (c_par(i) == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
      f[k] = flip_par ? ~p : p; k++;
    end
    for (int s = 0; s < c_sb(i); s++) begin
      f[k] = ~zero_stop; k++;
    end
    return f;
  endfunction

  // What a receiver should store for a given line frame: {frame_err, parity_err, data}.
  function automatic logic [10:0] decode(int i, logic [15:0] f);
    logic [8:0] d;
    int ones, k;
    logic pe, fe;
    d = '0; ones = 0; pe = 1'b0; fe = 1'b0;
    for (int b = 0; b < c_db(i); b++) begin
      d[b] = f[1+b]; ones += int'(f[1+b]);
    end
    k = 1 + c_db(i);
    if (c_par(i) != 0) begin
      ones += int'(f[k]);
      pe = (c_par(i) == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
      k++;
    end
    for (int s = 0; s < c_sb(i); s++) if (!f[k+s]) fe = 1'b1;
    return {fe, pe, d};
  endfunction

  function automatic logic [8:0] mask(int i, logic [8:0] d);
    logic [8:0] m;
    m = 9'((1 << c_db(i)) - 1);
    return d & m;
  endfunction

  task automatic model_push(input logic [10:0] e, input bit popping);
    if (popping && mq.size() > 0) begin
      void'(mq.pop_front());
      mq.push_back(e);
    end else if (mq.size() < 4) begin
      mq.push_back(e);
    end else begin
      movr = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic check_fifo(input int i, input string tag);
    logic [10:0] h;
    h = (mq.size() > 0) ? mq[0] : 11'd0;
    $display("txn %s: inst=%0d head=%0h perr=%b ferr=%b ovr=%b depth=%0d",
             tag, i, rdata[i], rperr[i], rferr[i], rovr[i], mq.size());
    chk({tag, ".ready"}, 32'(rready[i]), 32'(mq.size() > 0));
    chk({tag, ".data"},  32'(rdata[i]),  32'(h[8:0]));
    chk({tag, ".perr"},  32'(rperr[i]),  32'(h[9]));
    chk({tag, ".ferr"},  32'(rferr[i]),  32'(h[10]));
    chk({tag, ".ovr"},   32'(rovr[i]),   32'(movr));
  endtask

  task automatic pop_one(input int i, input string tag);
    pop[i] = 1'b1;
    @(negedge clk);
    pop[i] = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
    check_fifo(i, tag);
  endtask

  task automatic settle(input int i);
    repeat (2 * c_cd(i)) @(negedge clk);
  endtask

  task automatic wait_ready(input int i);
    int k;
    k = 0;
    while (!xready[i] && k < 1000) begin
      @(negedge clk); k++;
    end
    chk("ready_wait", 32'(xready[i]), 32'd1);
  endtask

  // Transmit one word and watch the line cycle by cycle from the accept cycle.
  task automatic send(input int i, input logic [8:0] d, input bit poke, input string tag);
    int n, cd, f;
    logic [15:0] seen;
    logic first_low, rdy_at_done;
    cd = c_cd(i); f = cd * c_nb(i);
    wait_ready(i);
    xdata[i] = d; xmit[i] = 1'b1;
    @(negedge clk);
    xmit[i] = 1'b0;
    seen = '0; n = 1; first_low = 1'b1; rdy_at_done = 1'b0;
    while (n <= f + 4) begin
      if (n == 1) first_low = txl[i];
      if (((n - 1) % cd) == cd / 2 && ((n - 1) / cd) < 16) seen[(n-1)/cd] = txl[i];
      if (xdone[i]) begin
        rdy_at_done = xready[i];
        break;
      end
      xmit[i] = poke && (n == 3 * cd);
      if (poke && n == 3 * cd) xdata[i] = ~d;
      @(negedge clk);
      n++;
    end
    xmit[i] = 1'b0;
    $display("txn %s: inst=%0d sent=%0h line=%0h done_at=%0d", tag, i, mask(i, d), seen, n);
    chk({tag, ".start"},   32'(first_low),   32'd0);
    chk({tag, ".bits"},    32'(seen),        32'(mk_frame(i, d, 1'b0, 1'b0)));
    chk({tag, ".done_at"}, 32'(n),           32'(f));
    chk({tag, ".rdy"},     32'(rdy_at_done), 32'd1);
    if (loopb[i]) model_push(decode(i, mk_frame(i, d, 1'b0, 1'b0)), 1'b0);
  endtask

  // Drive a raw frame onto the RX pin; optionally pulse pop in one chosen cycle.
  task automatic drive(input int i, input logic [15:0] f, input int pop_at, input string tag);
    int cd, nb;
    cd = c_cd(i); nb = c_nb(i);
    loopb[i] = 1'b0;
    for (int m = 0; m < nb * cd; m++) begin
      drv[i] = f[m/cd];
      pop[i] = (m == pop_at);
      @(negedge clk);
    end
    drv[i] = 1'b1;
    pop[i] = 1'b0;
    $display("txn %s: inst=%0d drove frame=%0h pop_at=%0d", tag, i, f, pop_at);
    model_push(decode(i, f), pop_at >= 0);
  endtask

  initial begin
    logic [8:0] d;
    int pop_at;
    for (int i = 0; i < 3; i++) begin
      xmit[i] = 1'b0; xdata[i] = '0; loopb[i] = 1'b1; drv[i] = 1'b1;
      pop[i] = 1'b0; clr[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst.tx",    32'(txl[i]),    32'd1);
      chk("rst.ready", 32'(xready[i]), 32'd1);
      chk("rst.done",  32'(xdone[i]),  32'd0);
    end
    check_fifo(0, "rst");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 loopback, fixed and random words
    send(0, 9'h0A5, 1'b0, "a5");
    settle(0); check_fifo(0, "a5.rx"); pop_one(0, "a5.pop");
    for (int r = 0; r < 3; r++) begin
      d = 9'($urandom_range(0, 255));
      send(0, d, 1'b0, "rnd");
      settle(0); check_fifo(0, "rnd.rx"); pop_one(0, "rnd.pop");
    end

    // request while busy must not be queued
    d = 9'($urandom_range(0, 255));
    send(0, d, 1'b1, "poke");
    repeat (c_cd(0)) @(negedge clk);
    chk("poke.idle_line",  32'(txl[0]),    32'd1);
    chk("poke.idle_ready", 32'(xready[0]), 32'd1);
    settle(0); check_fifo(0, "poke.rx"); pop_one(0, "poke.pop");

    // stop bit low -> frame error
    drive(0, mk_frame(0, 9'h03C, 1'b0, 1'b1), -1, "ferr");
    settle(0); check_fifo(0, "ferr.rx"); pop_one(0, "ferr.pop");

    // 3-cycle glitch is a false start
    drv[0] = 1'b0;
    repeat (3) @(negedge clk);
    drv[0] = 1'b1;
    repeat (40) @(negedge clk);
    check_fifo(0, "glitch");

    // five words into a four-deep FIFO
    for (int w = 0; w < 5; w++) begin
      d = 9'($urandom_range(0, 255));
      drive(0, mk_frame(0, d, 1'b0, 1'b0), -1, "fill");
    end
    settle(0); check_fifo(0, "ovr");
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    movr = 1'b0;
    check_fifo(0, "ovr.clr");

    // pop in the exact push cycle of a word arriving at a full FIFO
    pop_at = 2 + c_cd(0) / 2 + (c_nb(0) - 1) * c_cd(0);
    d = 9'($urandom_range(0, 255));
    drive(0, mk_frame(0, d, 1'b0, 1'b0), pop_at, "popsame");
    settle(0); check_fifo(0, "popsame.rx");
    for (int w = 0; w < 4; w++) pop_one(0, "drain");

    // reset in the middle of a frame with a word still queued
    drive(0, mk_frame(0, 9'h0C3, 1'b0, 1'b0), -1, "pre_rst");
    settle(0); check_fifo(0, "pre_rst.rx");
    loopb[0] = 1'b1;
    wait_ready(0);
    xdata[0] = 9'h055; xmit[0] = 1'b1;
    @(negedge clk);
    xmit[0] = 1'b0;
    repeat (39) @(negedge clk);
    chk("midrst.line_low", 32'(txl[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst.line",  32'(txl[0]),    32'd1);
    chk("midrst.ready", 32'(xready[0]), 32'd1);
    chk("midrst.rrdy",  32'(rready[0]), 32'd0);
    chk("midrst.rdata", 32'(rdata[0]),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete(); movr = 1'b0;
    repeat (200) @(negedge clk);
    check_fifo(0, "midrst.after");

    // 8E2: loopback, then a flipped parity bit
    send(1, 9'h007, 1'b0, "e07");
    settle(1); check_fifo(1, "e07.rx"); pop_one(1, "e07.pop");
    drive(1, mk_frame(1, 9'h007, 1'b1, 1'b0), -1, "perr");
    settle(1); check_fifo(1, "perr.rx"); pop_one(1, "perr.pop");
    loopb[1] = 1'b1;
    for (int r = 0; r < 2; r++) begin
      d = 9'($urandom_range(0, 255));
      send(1, d, 1'b0, "e.rnd");
      settle(1); check_fifo(1, "e.rnd.rx"); pop_one(1, "e.rnd.pop");
    end

    // 5O1 at four clocks per bit
    send(2, 9'h01F, 1'b0, "o1f");
    settle(2); check_fifo(2, "o1f.rx"); pop_one(2, "o1f.pop");
    for (int r = 0; r < 2; r++) begin
      d = 9'($urandom_range(0, 31));
      send(2, d, 1'b0, "o.rnd");
      settle(2); check_fifo(2, "o.rnd.rx"); pop_one(2, "o.rnd.pop");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
